// File: rtl/debug_run_ctrl.sv
// Debug run controller: decides in which cycles the CPU clock is enabled.
// Host commands: halt, free run, step N cycles, step N instructions, and
// set/clear a single PC breakpoint. o_run is registered and feeds clock gating.
//
// Ports:
//   i_clk, i_resetn      clock, asynchronous active-low reset
//   i_cmdValid/i_cmd     command strobe and opcode (accepted every valid cycle)
//   i_cmdArg             step count (low CNT_W bits) or breakpoint address
//   o_cmdReady           1 once out of reset
//   i_pc                 CPU program counter (next instruction on a finish pulse)
//   i_instrFinished      instruction-complete pulse, counted only while running
//   o_run                CPU clock enable for this cycle
//   o_state              0 HALTED, 1 RUNNING, 2 STEP_CYC, 3 STEP_INSTR
//   o_bpHit              sticky breakpoint-stop flag
//   o_remaining          step down-counter, 0 outside the step states
module debug_run_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned ARG_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_cmdValid,
  input  logic [2:0]        i_cmd,
  input  logic [ARG_W-1:0]  i_cmdArg,
  output logic              o_cmdReady,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_instrFinished,
  output logic              o_run,
  output logic [1:0]        o_state,
  output logic              o_bpHit,
  output logic [CNT_W-1:0]  o_remaining
);

  localparam logic [2:0] OP_HALT       = 3'd1;
  localparam logic [2:0] OP_RUN        = 3'd2;
  localparam logic [2:0] OP_STEP_CYC   = 3'd3;
  localparam logic [2:0] OP_STEP_INSTR = 3'd4;
  localparam logic [2:0] OP_SET_BP     = 3'd5;
  localparam logic [2:0] OP_CLR_BP     = 3'd6;

  typedef enum logic [1:0] {
    S_HALTED     = 2'd0,
    S_RUNNING    = 2'd1,
    S_STEP_CYC   = 2'd2,
    S_STEP_INSTR = 2'd3
  } state_e;

  state_e            r_state, w_state_nxt;
  logic              r_run, w_run_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_bp_hit, w_bp_hit_nxt;
  logic              r_bp_en, w_bp_en_nxt;
  logic [ADDR_W-1:0] r_bp_addr, w_bp_addr_nxt;
  logic              r_ready;

  logic              w_cmd_take;
  logic              w_bp_match;
  logic [CNT_W-1:0]  w_step_n;

  // Only state-changing opcodes preempt breakpoint and counter events.
  assign w_cmd_take = i_cmdValid &&
                      ((i_cmd == OP_HALT) || (i_cmd == OP_RUN) ||
                       (i_cmd == OP_STEP_CYC) || (i_cmd == OP_STEP_INSTR));

  // Breakpoint compares against the address held before any SET_BP this cycle.
  assign w_bp_match = r_run && i_instrFinished && r_bp_en && (i_pc == r_bp_addr) &&
                      ((r_state == S_RUNNING) || (r_state == S_STEP_INSTR));

  // A zero step count behaves as a single step.
  assign w_step_n = (i_cmdArg[CNT_W-1:0] == '0) ? CNT_W'(1) : i_cmdArg[CNT_W-1:0];

  // State and register update.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state   <= S_HALTED;
      r_run     <= 1'b0;
      r_cnt     <= '0;
      r_bp_hit  <= 1'b0;
      r_bp_en   <= 1'b0;
      r_bp_addr <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_run     <= w_run_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bp_hit  <= w_bp_hit_nxt;
      r_bp_en   <= w_bp_en_nxt;
      r_bp_addr <= w_bp_addr_nxt;
      r_ready   <= 1'b1;
    end
  end

  // Next state: command, then breakpoint, then counter expiry.
  always_comb begin
    w_state_nxt   = r_state;
    w_run_nxt     = r_run;
    w_cnt_nxt     = r_cnt;
    w_bp_hit_nxt  = r_bp_hit;
    w_bp_en_nxt   = r_bp_en;
    w_bp_addr_nxt = r_bp_addr;

    if (w_cmd_take) begin
      case (i_cmd)
        OP_HALT: begin
          w_state_nxt = S_HALTED;
          w_run_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end
        OP_RUN: begin
          w_state_nxt  = S_RUNNING;
          w_run_nxt    = 1'b1;
          w_cnt_nxt    = '0;
          w_bp_hit_nxt = 1'b0;
        end
        OP_STEP_CYC: begin
          w_state_nxt  = S_STEP_CYC;
          w_run_nxt    = 1'b1;
          w_cnt_nxt    = w_step_n;
          w_bp_hit_nxt = 1'b0;
        end
        OP_STEP_INSTR: begin
          w_state_nxt  = S_STEP_INSTR;
          w_run_nxt    = 1'b1;
          w_cnt_nxt    = w_step_n;
          w_bp_hit_nxt = 1'b0;
        end
        default: ;
      endcase
    end else if (w_bp_match) begin
      w_state_nxt  = S_HALTED;
      w_run_nxt    = 1'b0;
      w_cnt_nxt    = '0;
      w_bp_hit_nxt = 1'b1;
    end else begin
      case (r_state)
        S_STEP_CYC: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = S_HALTED;
            w_run_nxt   = 1'b0;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_STEP_INSTR: begin
          if (i_instrFinished) begin
            if (r_cnt <= CNT_W'(1)) begin
              w_state_nxt = S_HALTED;
              w_run_nxt   = 1'b0;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt - CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end

    // Breakpoint programming is orthogonal to the run state.
    if (i_cmdValid && (i_cmd == OP_SET_BP)) begin
      w_bp_en_nxt   = 1'b1;
      w_bp_addr_nxt = i_cmdArg[ADDR_W-1:0];
    end else if (i_cmdValid && (i_cmd == OP_CLR_BP)) begin
      w_bp_en_nxt = 1'b0;
    end
  end

  assign o_cmdReady  = r_ready;
  assign o_run       = r_run;
  assign o_state     = 2'(r_state);
  assign o_bpHit     = r_bp_hit;
  assign o_remaining = r_cnt;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Bench for debug_run_ctrl: behavioural model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_debug_run_ctrl;

  logic        i_clk = 1'b0;
  logic        i_resetn = 1'b0;
  logic        i_cmdValid = 1'b0;
  logic [2:0]  i_cmd = 3'd0;
  logic [15:0] i_cmdArg = 16'd0;
  logic        o_cmdReady;
  logic [15:0] i_pc = 16'd0;
  logic        i_instrFinished = 1'b0;
  logic        o_run;
  logic [1:0]  o_state;
  logic        o_bpHit;
  logic [15:0] o_remaining;

  debug_run_ctrl #(.ADDR_W(16), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_cmdValid(i_cmdValid), .i_cmd(i_cmd),
    .i_cmdArg(i_cmdArg), .o_cmdReady(o_cmdReady), .i_pc(i_pc),
    .i_instrFinished(i_instrFinished), .o_run(o_run), .o_state(o_state),
    .o_bpHit(o_bpHit), .o_remaining(o_remaining)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: mode 0 halted, 1 free run, 2 cycle steps, 3 instruction steps.
  // "left" is how many more cycles/instructions the current step may use.
  int          m_mode;
  int unsigned m_left;
  bit          m_bp_on;
  int unsigned m_bp_at;
  bit          m_hit;
  bit          m_ready;
  bit          mm_match;
  bit          mm_took;
  int unsigned mm_n;

  always @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      m_mode = 0; m_left = 0; m_bp_on = 0; m_bp_at = 0; m_hit = 0; m_ready = 0;
    end else begin
      m_ready  = 1;
      mm_n     = (i_cmdArg == 16'd0) ? 1 : int'(i_cmdArg);
      mm_match = (m_mode == 1 || m_mode == 3) && i_instrFinished && m_bp_on &&
                 (int'(i_pc) == m_bp_at);
      mm_took  = 0;
      if (i_cmdValid) begin
        if (i_cmd == 3'd1) begin m_mode = 0; m_left = 0; mm_took = 1; end
        if (i_cmd == 3'd2) begin m_mode = 1; m_left = 0; m_hit = 0; mm_took = 1; end
        if (i_cmd == 3'd3) begin m_mode = 2; m_left = mm_n; m_hit = 0; mm_took = 1; end
        if (i_cmd == 3'd4) begin m_mode = 3; m_left = mm_n; m_hit = 0; mm_took = 1; end
      end
      if (!mm_took) begin
        if (mm_match) begin
          m_mode = 0; m_left = 0; m_hit = 1;
        end else if (m_mode == 2 || (m_mode == 3 && i_instrFinished)) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 0;
        end
      end
      if (i_cmdValid && i_cmd == 3'd5) begin m_bp_on = 1; m_bp_at = int'(i_cmdArg); end
      if (i_cmdValid && i_cmd == 3'd6) m_bp_on = 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    chk("ready", 32'(o_cmdReady), 32'(m_ready));
    chk("run", 32'(o_run), (m_mode != 0) ? 32'd1 : 32'd0);
    chk("state", 32'(o_state), 32'(m_mode));
    chk("bphit", 32'(o_bpHit), 32'(m_hit));
    chk("remaining", 32'(o_remaining), 32'(m_left));
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge i_clk); @(negedge i_clk); end
  endtask

  task automatic cmd(input logic [2:0] c, input logic [15:0] a);
    i_cmdValid = 1'b1; i_cmd = c; i_cmdArg = a;
    tick(1);
    i_cmdValid = 1'b0; i_cmd = 3'd0; i_cmdArg = 16'd0;
  endtask

  task automatic pulse(input logic [15:0] pc);
    i_pc = pc; i_instrFinished = 1'b1;
    tick(1);
    i_instrFinished = 1'b0; i_pc = 16'd0;
  endtask

  int runs;

  initial begin
    // Reset and idle; pulses while halted are ignored.
    tick(3);
    i_resetn = 1'b1;
    tick(2);
    chk("idle_run", 32'(o_run), 32'd0);
    chk("idle_state", 32'(o_state), 32'd0);
    chk("idle_ready", 32'(o_cmdReady), 32'd1);
    pulse(16'h0042); pulse(16'h0010);
    chk("idle_pulse_run", 32'(o_run), 32'd0);

    // STEP_CYC 5: counter 5..1 while running, then halted.
    cmd(3'd3, 16'd5);
    for (int i = 0; i < 5; i++) begin
      chk("cyc5_run", 32'(o_run), 32'd1);
      chk("cyc5_rem", 32'(o_remaining), 32'(5 - i));
      tick(1);
    end
    chk("cyc5_end", 32'(o_run), 32'd0);
    chk("cyc5_state", 32'(o_state), 32'd0);

    // STEP_CYC 0 runs exactly one cycle.
    cmd(3'd3, 16'd0);
    runs = 0;
    for (int i = 0; i < 5; i++) begin if (o_run) runs++; tick(1); end
    chk("cyc0_runs", 32'(runs), 32'd1);

    // STEP_INSTR 3 with a pulse every 4 cycles.
    cmd(3'd4, 16'd3);
    for (int k = 0; k < 3; k++) begin
      tick(3);
      pulse(16'h0100);
      if (k < 2) chk("si3_rem", 32'(o_remaining), 32'(2 - k));
    end
    chk("si3_stop", 32'(o_run), 32'd0);
    pulse(16'h0100); pulse(16'h0100);
    chk("si3_halt_rem", 32'(o_remaining), 32'd0);

    // Breakpoint during RUN, then RUN clears the flag.
    cmd(3'd5, 16'h0042);
    cmd(3'd2, 16'd0);
    tick(2);
    pulse(16'h0010);
    chk("bp_miss_run", 32'(o_run), 32'd1);
    tick(1);
    pulse(16'h0042);
    chk("bp_hit_run", 32'(o_run), 32'd0);
    chk("bp_hit_flag", 32'(o_bpHit), 32'd1);
    cmd(3'd2, 16'd0);
    chk("bp_clr_flag", 32'(o_bpHit), 32'd0);
    cmd(3'd1, 16'd0);

    // STEP_CYC ignores the breakpoint.
    cmd(3'd3, 16'd10);
    runs = 0;
    for (int i = 0; i < 14; i++) begin
      if (o_run) runs++;
      i_pc = 16'h0042; i_instrFinished = (i == 3);
      tick(1);
    end
    i_instrFinished = 1'b0;
    chk("cyc10_runs", 32'(runs), 32'd10);
    chk("cyc10_flag", 32'(o_bpHit), 32'd0);

    // STEP_INSTR 5 stops at the breakpoint.
    cmd(3'd4, 16'd5);
    pulse(16'h0010);
    tick(1);
    pulse(16'h0042);
    chk("si5_stop", 32'(o_run), 32'd0);
    chk("si5_flag", 32'(o_bpHit), 32'd1);

    // HALT coinciding with a breakpoint match wins.
    cmd(3'd2, 16'd0);
    tick(1);
    i_pc = 16'h0042; i_instrFinished = 1'b1;
    cmd(3'd1, 16'd0);
    i_instrFinished = 1'b0;
    chk("halt_prio_state", 32'(o_state), 32'd0);
    chk("halt_prio_flag", 32'(o_bpHit), 32'd0);

    // Reset during a long step aborts it and clears the breakpoint.
    cmd(3'd3, 16'd100);
    tick(3);
    #2 i_resetn = 1'b0;
    #1;
    chk("rst_run", 32'(o_run), 32'd0);
    chk("rst_rem", 32'(o_remaining), 32'd0);
    chk("rst_ready", 32'(o_cmdReady), 32'd0);
    tick(1);
    i_resetn = 1'b1;
    tick(1);
    cmd(3'd2, 16'd0);
    pulse(16'h0042);
    chk("rst_bp_cleared", 32'(o_run), 32'd1);
    cmd(3'd1, 16'd0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
